// File: rtl/uart_buffered_tx_if.sv
// Write-port handshake between a word producer and the buffered UART transmitter.
interface uart_buffered_tx_if #(
    parameter int unsigned BITS_PER_WORD = 8
);
    logic [BITS_PER_WORD-1:0] wr_data;
    logic                     wr_valid;
    logic                     wr_ready;

    modport master (output wr_data, output wr_valid, input wr_ready);
    modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/uart_buffered_tx.sv
// Buffered 8N1-style UART transmitter: valid/ready write port into a circular FIFO,
// drained back-to-back onto the serial line at CLK_RATE/BAUD_RATE cycles per bit.
module uart_buffered_tx #(
    parameter int unsigned CLK_RATE      = 50000000,
    parameter int unsigned BAUD_RATE     = 115200,
    parameter int unsigned BITS_PER_WORD = 8,
    parameter int unsigned FIFO_DEPTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    uart_buffered_tx_if.slave             wr,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int unsigned CLKS_PER_BIT = CLK_RATE / BAUD_RATE;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned COUNT_W      = PTR_W + 1;
    localparam int unsigned IDX_W        = $clog2(BITS_PER_WORD);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [BITS_PER_WORD-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [COUNT_W-1:0]       r_count;
    logic                     r_overflow;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CNT_W-1:0]         r_clk_cnt;
    logic [CNT_W-1:0]         w_clk_cnt_next;
    logic [IDX_W-1:0]         r_bit_idx;
    logic [IDX_W-1:0]         w_bit_idx_next;
    logic [BITS_PER_WORD-1:0] r_shift;
    logic [BITS_PER_WORD-1:0] w_shift_next;
    logic                     r_tx;
    logic                     w_tx_next;

    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_bit_end;

    assign w_full    = (r_count == COUNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = wr.wr_valid && !w_full;
    assign w_bit_end = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

    assign wr.wr_ready = !w_full;
    assign tx          = r_tx;
    assign busy        = (r_state != S_IDLE) || !w_empty;
    assign fifo_count  = r_count;
    assign overflow    = r_overflow;

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr.wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wr.wr_valid && w_full;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + COUNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_clk_cnt <= w_clk_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

    // Next-state and line value; tx is computed one cycle ahead so the pin is a flop.
    always_comb begin
        w_state_next   = r_state;
        w_clk_cnt_next = w_bit_end ? '0 : r_clk_cnt + CNT_W'(1);
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_tx_next      = r_tx;
        w_pop          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_clk_cnt_next = '0;
                w_tx_next      = 1'b1;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_mem[r_rd_ptr];
                    w_tx_next    = 1'b0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_tx_next      = r_shift[0];
                    w_shift_next   = r_shift >> 1;
                    w_bit_idx_next = '0;
                    w_state_next   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == IDX_W'(BITS_PER_WORD - 1)) begin
                        w_tx_next    = 1'b1;
                        w_state_next = S_STOP;
                    end else begin
                        w_tx_next      = r_shift[0];
                        w_shift_next   = r_shift >> 1;
                        w_bit_idx_next = r_bit_idx + IDX_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = r_mem[r_rd_ptr];
                        w_tx_next    = 1'b0;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_buffered_tx.sv
// Scoreboarded bench: expected words queued at write time, frames decoded off tx and compared.
module tb_uart_buffered_tx;
    localparam int unsigned CLK_RATE  = 1000000;
    localparam int unsigned BAUD_RATE = 62500;
    localparam int unsigned CPB       = CLK_RATE / BAUD_RATE;
    localparam int unsigned FRAME     = 10 * CPB;
    localparam int unsigned DEPTH     = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx;
    logic       busy;
    logic [4:0] fifo_count;
    logic       overflow;
    int         cyc = 0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] sb[$];
    int         starts[$];

    uart_buffered_tx_if #(.BITS_PER_WORD(8)) wr_if ();

    uart_buffered_tx #(
        .CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE),
        .BITS_PER_WORD(8), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr_if),
        .tx(tx), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic skip(input int n, inout bit ab);
        for (int i = 0; i < n && !ab; i++) begin
            @(negedge clk);
            if (!rst_n) ab = 1'b1;
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_idle(input int limit, output int t);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clk);
            if (busy == 1'b0) break;
        end
        if (i == limit) check("busy_timeout", 32'(1), 32'(0));
        t = cyc;
    endtask

    // Line decoder: samples first and last cycle of each of the 10 bits.
    initial begin : monitor
        logic [9:0] first_s;
        logic [9:0] last_s;
        logic [7:0] exp;
        bit         ab;
        forever begin
            @(negedge clk);
            if (rst_n && tx == 1'b0) begin
                starts.push_back(cyc);
                ab = 1'b0;
                first_s = '0;
                last_s  = '0;
                for (int j = 0; j < 10 && !ab; j++) begin
                    first_s[j] = tx;
                    skip(CPB - 1, ab);
                    last_s[j] = tx;
                    if (j < 9) skip(1, ab);
                end
                if (!ab) begin
                    if (sb.size() == 0) begin
                        check("spurious_frame", 32'(1), 32'(0));
                    end else begin
                        exp = sb.pop_front();
                        check("frame_bits", 32'(last_s), 32'({1'b1, exp, 1'b0}));
                        check("bit_width", 32'(first_s), 32'(last_s));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  ce;
        int  s0;
        int  t;
        bit  saw_low;

        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;

        // Reset and idle line
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tx", 32'(tx), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ready", 32'(wr_if.wr_ready), 32'(1));
        check("rst_count", 32'(fifo_count), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        saw_low = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        check("idle_tx_high", 32'(saw_low), 32'(0));

        // Single word 0xA5
        starts.delete();
        sb.push_back(8'hA5);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 8'hA5;
        @(negedge clk);
        ce = cyc;
        wr_if.wr_valid = 1'b0;
        check("single_count", 32'(fifo_count), 32'(1));
        wait_idle(20 * CPB, t);
        check("single_frames", 32'(starts.size()), 32'(1));
        if (starts.size() >= 1) check("single_start", 32'(starts[0]), 32'(ce + 1));
        check("single_busy_fall", 32'(t), 32'(ce + 1 + FRAME));
        check("single_sb_empty", 32'(sb.size()), 32'(0));

        // Burst 0x55, 0x00, 0xFF
        starts.delete();
        sb.push_back(8'h55);
        sb.push_back(8'h00);
        sb.push_back(8'hFF);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 8'h55;
        @(negedge clk);
        ce = cyc;
        wr_if.wr_data = 8'h00;
        @(negedge clk);
        wr_if.wr_data = 8'hFF;
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        check("burst_count", 32'(fifo_count), 32'(2));
        wait_idle(40 * CPB, t);
        check("burst_frames", 32'(starts.size()), 32'(3));
        if (starts.size() == 3) begin
            check("burst_start", 32'(starts[0]), 32'(ce + 1));
            check("burst_gap1", 32'(starts[1] - starts[0]), 32'(FRAME));
            check("burst_gap2", 32'(starts[2] - starts[1]), 32'(FRAME));
            check("burst_total", 32'(t - starts[0]), 32'(3 * FRAME));
        end
        check("burst_sb_empty", 32'(sb.size()), 32'(0));

        // Fill: 18 writes, 17 accepted, one overflow
        starts.delete();
        for (int k = 0; k < 17; k++) sb.push_back(8'(16 + k));
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 8'(16);
        for (int k = 1; k < 18; k++) begin
            @(negedge clk);
            if (k == 1) ce = cyc;
            if (k == 17) begin
                check("fill_ready_low", 32'(wr_if.wr_ready), 32'(0));
                check("fill_count_full", 32'(fifo_count), 32'(DEPTH));
                check("fill_no_ovf_yet", 32'(overflow), 32'(0));
            end
            wr_if.wr_data = 8'(16 + k);
        end
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        check("fill_overflow", 32'(overflow), 32'(1));
        check("fill_count_hold", 32'(fifo_count), 32'(DEPTH));
        @(negedge clk);
        check("fill_overflow_pulse", 32'(overflow), 32'(0));
        wait_until(ce + 1 + FRAME);
        check("fill_count_15", 32'(fifo_count), 32'(15));
        wait_until(ce + 1 + 2 * FRAME);
        check("fill_count_14", 32'(fifo_count), 32'(14));
        wait_idle(20 * FRAME, t);
        check("fill_frames", 32'(starts.size()), 32'(17));
        check("fill_sb_empty", 32'(sb.size()), 32'(0));

        // Pop and write on the same edge at fifo_count=1
        starts.delete();
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        sb.push_back(8'h33);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 8'h11;
        @(negedge clk);
        ce = cyc;
        s0 = ce + 1;
        wr_if.wr_valid = 1'b0;
        wait_until(s0 + 3 * CPB);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 8'h22;
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        check("simul_pre_count", 32'(fifo_count), 32'(1));
        wait_until(s0 + FRAME - 1);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 8'h33;
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        check("simul_count_hold", 32'(fifo_count), 32'(1));
        wait_idle(40 * CPB, t);
        check("simul_frames", 32'(starts.size()), 32'(3));
        if (starts.size() == 3) check("simul_gap", 32'(starts[2] - starts[1]), 32'(FRAME));
        check("simul_sb_empty", 32'(sb.size()), 32'(0));

        // Reset during data bit 3 of 0x3C with another word queued
        starts.delete();
        sb.push_back(8'h3C);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 8'h3C;
        @(negedge clk);
        ce = cyc;
        s0 = ce + 1;
        wr_if.wr_data = 8'h99;
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        wait_until(s0 + 4 * CPB + CPB / 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx), 32'(1));
        check("mid_rst_count", 32'(fifo_count), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        starts.delete();
        sb.push_back(8'h81);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 8'h81;
        @(negedge clk);
        ce = cyc;
        wr_if.wr_valid = 1'b0;
        wait_idle(20 * CPB, t);
        check("post_rst_frames", 32'(starts.size()), 32'(1));
        check("post_rst_busy_fall", 32'(t), 32'(ce + 1 + FRAME));
        check("post_rst_sb_empty", 32'(sb.size()), 32'(0));

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
